axis_width_upsizer: RTL



---
 rtl/axis_pkg.sv | 17 +
 rtl/axis_width_upsizer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/axis_pkg.sv
// axis_pkg: helpers shared by the AXI Stream width-conversion blocks.
//   MAX_RATIO  - widest keep mask keep_mask() can describe.
//   keep_mask  - contiguous low-ones mask covering lanes 0..lane.
package axis_pkg;

  localparam int MAX_RATIO = 64;

  // Lanes 0..lane set, all higher lanes clear.
  function automatic logic [MAX_RATIO-1:0] keep_mask(input int lane);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_RATIO; i++)
      if (i <= lane) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/axis_width_upsizer.sv
// axis_width_upsizer: packs RATIO narrow AXI Stream beats into one wide beat.
// A tlast beat flushes a partial word; tkeep marks the filled low lanes and
// unkept lanes carry zero data. The output is fully registered.
// Ports:
//   clk_i, arst_i            clock, async active-high reset
//   s_axis_*                 narrow input stream (tdata/tvalid/tlast/tuser/tready)
//   m_axis_*                 wide output stream (tdata/tkeep/tvalid/tlast/tuser/tready)
module axis_width_upsizer
  import axis_pkg::*;
#(
  parameter int S_DATA_WIDTH = 8,
  parameter int RATIO        = 4,
  parameter int TUSER_WIDTH  = 1
) (
  input  logic                             clk_i,
  input  logic                             arst_i,
  input  logic [S_DATA_WIDTH-1:0]          s_axis_tdata_i,
  input  logic                             s_axis_tvalid_i,
  input  logic                             s_axis_tlast_i,
  input  logic [TUSER_WIDTH-1:0]           s_axis_tuser_i,
  output logic                             s_axis_tready_o,
  input  logic                             m_axis_tready_i,
  output logic [S_DATA_WIDTH*RATIO-1:0]    m_axis_tdata_o,
  output logic [RATIO-1:0]                 m_axis_tkeep_o,
  output logic                             m_axis_tvalid_o,
  output logic                             m_axis_tlast_o,
  output logic [TUSER_WIDTH-1:0]           m_axis_tuser_o
);

  localparam int M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
  localparam int LANE_W       = $clog2(RATIO);

  // Assembly state: lanes 0..RATIO-2 (the last lane is always the live beat).
  logic [LANE_W-1:0]                   lane_q, lane_d;
  logic [RATIO-2:0][S_DATA_WIDTH-1:0]  asm_q, asm_d;
  logic [TUSER_WIDTH-1:0]              acc_q, acc_d;

  // Output register.
  logic [RATIO-1:0][S_DATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic [RATIO-1:0]                    m_keep_q, m_keep_d;
  logic                                m_last_q, m_last_d;
  logic [TUSER_WIDTH-1:0]              m_user_q, m_user_d;
  logic                                m_valid_q, m_valid_d;

  logic                                accept, complete, lane_full;
  logic [RATIO-1:0][S_DATA_WIDTH-1:0]  word;
  logic [MAX_RATIO-1:0]                keep_full;
  logic                                unused_keep;

  // Ready only looks at the downstream, never at the input beat itself.
  assign s_axis_tready_o = !m_valid_q | m_axis_tready_i;

  assign lane_full = (lane_q == LANE_W'(RATIO - 1));
  assign accept    = s_axis_tvalid_i & s_axis_tready_o;
  assign complete  = accept & (lane_full | s_axis_tlast_i);

  assign keep_full   = keep_mask(int'(lane_q));
  assign unused_keep = ^keep_full[MAX_RATIO-1:RATIO];

  // Word being completed: stored lanes below lane_q, live beat at lane_q,
  // zeros above so unkept lanes never leak stale assembly data.
  always_comb begin
    word = '0;
    for (int i = 0; i < RATIO - 1; i++)
      if (LANE_W'(i) < lane_q) word[i] = asm_q[i];
    for (int i = 0; i < RATIO; i++)
      if (LANE_W'(i) == lane_q) word[i] = s_axis_tdata_i;
  end

  always_comb begin
    lane_d    = lane_q;
    asm_d     = asm_q;
    acc_d     = acc_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;
    m_valid_d = m_valid_q;

    // Downstream took the word; a same-cycle completion below overrides.
    if (m_valid_q && m_axis_tready_i) m_valid_d = 1'b0;

    if (complete) begin
      m_data_d  = word;
      m_keep_d  = keep_full[RATIO-1:0];
      m_last_d  = s_axis_tlast_i;
      m_user_d  = acc_q | s_axis_tuser_i;
      m_valid_d = 1'b1;
      lane_d    = '0;
      acc_d     = '0;
    end else if (accept) begin
      for (int i = 0; i < RATIO - 1; i++)
        if (LANE_W'(i) == lane_q) asm_d[i] = s_axis_tdata_i;
      acc_d  = acc_q | s_axis_tuser_i;
      lane_d = lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      lane_q    <= '0;
      asm_q     <= '0;
      acc_q     <= '0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_user_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      asm_q     <= asm_d;
      acc_q     <= acc_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_axis_tdata_o  = M_DATA_WIDTH'(m_data_q);
  assign m_axis_tkeep_o  = m_keep_q;
  assign m_axis_tlast_o  = m_last_q;
  assign m_axis_tuser_o  = m_user_q;
  assign m_axis_tvalid_o = m_valid_q;

endmodule
